// File: rtl/data_mem_responder.sv
// Handshaked data-memory target for the load/store path: accepts a request while idle,
// answers with a one-cycle ack LATENCY cycles later, and flags out-of-range accesses.
module data_mem_responder #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [7:0]        acc_cnt,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    state_t            state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic finish;
    logic hit;
    logic dump_hit;

    assign accept   = (state_q == S_IDLE) && req;
    assign finish   = (state_q == S_WAIT) && (cnt_q == '0);
    assign hit      = {1'b0, addr_q} < DEPTH_LIM;
    assign dump_hit = {1'b0, dump_addr} < DEPTH_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, wait counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            acc_cnt <= 8'd0;
        end else begin
            if (accept) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt_q   <= CNT_LOAD;
                busy    <= 1'b1;
            end
            if ((state_q == S_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                ack     <= 1'b1;
                acc_cnt <= acc_cnt + 8'd1;
                if (hit) begin
                    if (!wr_q) rdata <= mem[addr_q];
                end else begin
                    err <= 1'b1;
                    if (!wr_q) rdata <= '0;
                end
            end
            if (state_q == S_RESP) begin
                ack  <= 1'b0;
                err  <= 1'b0;
                busy <= 1'b0;
            end
        end
    end

    // Writes commit only on the completing edge, so an aborted transaction never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (finish && hit && wr_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign dump_data = dump_hit ? mem[dump_addr] : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with DEPTH=12/LATENCY=2 (unit a), one with DEPTH=16/LATENCY=1 (unit b).
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_req, a_wr, a_busy, a_ack, a_err;
    logic [3:0] a_addr, a_wdata, a_rdata, a_dump_addr, a_dump_data;
    logic [7:0] a_cnt;

    logic       b_req, b_wr, b_busy, b_ack, b_err;
    logic [3:0] b_addr, b_wdata, b_rdata, b_dump_addr, b_dump_data;
    logic [7:0] b_cnt;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_mem [16];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .LATENCY(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .wr(a_wr), .addr(a_addr), .wdata(a_wdata),
        .busy(a_busy), .ack(a_ack), .rdata(a_rdata), .err(a_err), .acc_cnt(a_cnt),
        .dump_addr(a_dump_addr), .dump_data(a_dump_data)
    );

    data_mem_responder #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
        .busy(b_busy), .ack(b_ack), .rdata(b_rdata), .err(b_err), .acc_cnt(b_cnt),
        .dump_addr(b_dump_addr), .dump_data(b_dump_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request, waits (bounded) for ack, then steps through the RESP cycle.
    task automatic run_access(input bit sel_b, input logic w, input logic [3:0] a,
                              input logic [3:0] d, output int lat, output logic busy_e0,
                              output logic [3:0] rd, output logic er);
        if (sel_b) begin
            b_req = 1'b1; b_wr = w; b_addr = a; b_wdata = d;
        end else begin
            a_req = 1'b1; a_wr = w; a_addr = a; a_wdata = d;
        end
        tick;
        busy_e0 = sel_b ? b_busy : a_busy;
        a_req = 1'b0;
        b_req = 1'b0;
        lat = 0;
        rd = '0;
        er = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if ((sel_b ? b_ack : a_ack) === 1'b1) begin
                lat = i;
                rd = sel_b ? b_rdata : a_rdata;
                er = sel_b ? b_err : a_err;
                break;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin
            exp_mem[i] = '0;
            a_dump_addr = 4'(i);
            #1;
            checks++;
            if (a_dump_data !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset_dump[%0d]: got %0d expected 0", i, a_dump_data);
            end
        end
        checks++;
        if (a_busy !== 1'b0 || a_ack !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got busy=%b ack=%b err=%b expected 0 0 0", a_busy, a_ack, a_err);
        end
        checks++;
        if (a_cnt !== 8'd0 || a_rdata !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got cnt=%0d rdata=%0d expected 0 0", a_cnt, a_rdata);
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic be0, er;
        logic [3:0] rd;
        run_access(1'b0, 1'b1, 4'd3, 4'd9, lat, be0, rd, er);
        exp_mem[3] = 4'd9;
        checks++;
        if (be0 !== 1'b1 || lat != 2) begin
            errors++;
            $display("[TB] FAIL write_timing: got busy_e0=%b lat=%0d expected 1 2", be0, lat);
        end
        checks++;
        if (a_ack !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_release: got ack=%b busy=%b expected 0 0", a_ack, a_busy);
        end
        a_dump_addr = 4'd3;
        #1;
        checks++;
        if (a_dump_data !== 4'd9) begin
            errors++;
            $display("[TB] FAIL write_commit: got %0d expected 9", a_dump_data);
        end
        run_access(1'b0, 1'b0, 4'd3, 4'd0, lat, be0, rd, er);
        checks++;
        if (lat != 2 || rd !== 4'd9 || er !== 1'b0 || a_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL read_back: got lat=%0d rdata=%0d err=%b cnt=%0d expected 2 9 0 2",
                     lat, rd, er, a_cnt);
        end
    endtask

    task automatic test_busy_ignore;
        int acks = 0;
        for (int i = 0; i < 16; i++) begin
            a_req = 1'b1;
            a_wr = (i % 2 == 0);
            a_addr = 4'(5 + i % 3);
            a_wdata = 4'(i + 1);
            tick;
            if (a_ack === 1'b1) acks++;
        end
        a_req = 1'b0;
        repeat (4) begin
            tick;
            if (a_ack === 1'b1) acks++;
        end
        exp_mem[5] = 4'd13;
        exp_mem[6] = 4'd5;
        exp_mem[7] = 4'd9;
        checks++;
        if (acks != 4 || a_cnt !== 8'd6) begin
            errors++;
            $display("[TB] FAIL busy_acks: got acks=%0d cnt=%0d expected 4 6", acks, a_cnt);
        end
        for (int i = 5; i <= 7; i++) begin
            a_dump_addr = 4'(i);
            #1;
            checks++;
            if (a_dump_data !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL busy_mem[%0d]: got %0d expected %0d", i, a_dump_data, exp_mem[i]);
            end
        end
        checks++;
        if (a_rdata !== 4'd9) begin
            errors++;
            $display("[TB] FAIL rdata_hold: got %0d expected 9", a_rdata);
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        logic be0, er;
        logic [3:0] rd;
        run_access(1'b0, 1'b1, 4'd13, 4'd5, lat, be0, rd, er);
        checks++;
        if (lat != 2 || er !== 1'b1 || a_rdata !== 4'd9 || a_cnt !== 8'd7) begin
            errors++;
            $display("[TB] FAIL oor_write: got lat=%0d err=%b rdata=%0d cnt=%0d expected 2 1 9 7",
                     lat, er, a_rdata, a_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            a_dump_addr = 4'(i);
            #1;
            checks++;
            if (a_dump_data !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL oor_mem[%0d]: got %0d expected %0d", i, a_dump_data, exp_mem[i]);
            end
        end
        run_access(1'b0, 1'b0, 4'd14, 4'd0, lat, be0, rd, er);
        checks++;
        if (lat != 2 || rd !== 4'd0 || er !== 1'b1 || a_cnt !== 8'd8) begin
            errors++;
            $display("[TB] FAIL oor_read: got lat=%0d rdata=%0d err=%b cnt=%0d expected 2 0 1 8",
                     lat, rd, er, a_cnt);
        end
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear: got %b expected 0", a_err);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int acks = 0;
        logic be0, er;
        logic [3:0] rd;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 4'd1; a_wdata = 4'd7;
        tick;
        a_req = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        if (a_ack === 1'b1) acks++;
        tick;
        if (a_ack === 1'b1) acks++;
        rst_n = 1'b1;
        repeat (2) begin
            tick;
            if (a_ack === 1'b1) acks++;
        end
        a_dump_addr = 4'd1;
        #1;
        checks++;
        if (acks != 0 || a_dump_data !== 4'd0 || a_cnt !== 8'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort: got acks=%0d mem1=%0d cnt=%0d busy=%b expected 0 0 0 0",
                     acks, a_dump_data, a_cnt, a_busy);
        end
        run_access(1'b0, 1'b0, 4'd1, 4'd0, lat, be0, rd, er);
        checks++;
        if (lat != 2 || rd !== 4'd0 || a_cnt !== 8'd1) begin
            errors++;
            $display("[TB] FAIL abort_idle: got lat=%0d rdata=%0d cnt=%0d expected 2 0 1", lat, rd, a_cnt);
        end
    endtask

    task automatic test_latency1;
        int lat;
        logic be0, er;
        logic [3:0] rd;
        run_access(1'b1, 1'b1, 4'd2, 4'd11, lat, be0, rd, er);
        checks++;
        if (lat != 1 || be0 !== 1'b1 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lat1_write: got lat=%0d busy_e0=%b err=%b expected 1 1 0", lat, be0, er);
        end
        run_access(1'b1, 1'b0, 4'd2, 4'd0, lat, be0, rd, er);
        checks++;
        if (lat != 1 || rd !== 4'd11 || b_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL lat1_read: got lat=%0d rdata=%0d cnt=%0d expected 1 11 2", lat, rd, b_cnt);
        end
        b_dump_addr = 4'd15;
        #1;
        checks++;
        if (b_dump_data !== 4'd0) begin
            errors++;
            $display("[TB] FAIL lat1_dump15: got %0d expected 0", b_dump_data);
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic be0, er;
        logic [3:0] rd;
        for (int i = 0; i < 253; i++) run_access(1'b1, 1'b0, 4'd2, 4'd0, lat, be0, rd, er);
        checks++;
        if (b_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL cnt_255: got %0d expected 255", b_cnt);
        end
        run_access(1'b1, 1'b0, 4'd2, 4'd0, lat, be0, rd, er);
        checks++;
        if (b_cnt !== 8'd0 || rd !== 4'd11) begin
            errors++;
            $display("[TB] FAIL cnt_wrap: got cnt=%0d rdata=%0d expected 0 11", b_cnt, rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_dump_addr = '0;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_dump_addr = '0;
        test_reset;
        test_write_read;
        test_busy_ignore;
        test_out_of_range;
        test_reset_abort;
        test_latency1;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
